// File: rtl/ts_udp_packer.sv
// TS-to-UDP packer: gathers 188-byte TS packets into double-buffered frames and bursts them out.
// Optional macro NULL_PID_DROP_EN discards null packets (PID 0x1FFF) before they are committed.
module ts_udp_packer #(
  parameter int PKTS_PER_FRAME = 7,
  parameter int TIMEOUT_CYC    = 125000
) (
  input  logic        tx_clk,
  input  logic        tx_rst,
  input  logic [7:0]  ts_din,
  input  logic        ts_din_en,
  input  logic        ts_din_sync,
  input  logic        udp_prog_full,
  output logic [7:0]  udp_din,
  output logic        udp_din_en,
  output logic [10:0] udp_frame_len,
  output logic [15:0] drop_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_READ, S_GAP} rd_state_t;

  logic [7:0]        r_mem [0:4095];
  logic              r_wbank, r_open, r_tmr_run;
  logic [7:0]        r_bcnt;
  logic [10:0]       r_base;
  logic [2:0]        r_npkt;
  logic [1:0]        r_ready;
  logic [1:0][10:0]  r_flen;
  logic [TW-1:0]     r_tcnt;
  logic [15:0]       r_drop;

  rd_state_t         r_st, w_st_nxt;
  logic              r_rbank;
  logic [10:0]       r_raddr, r_len;
  logic [1:0]        r_vld_pipe;
  logic [7:0]        r_rdata, r_dout;

  logic              w_sop, w_drop, w_accept, w_byte, w_null, w_commit;
  logic              w_tmo, w_full, w_close, w_we, w_free, w_latch;
  logic [7:0]        w_off;
  logic [11:0]       w_waddr;
  logic [10:0]       w_close_len;

  assign w_sop    = ts_din_en & ts_din_sync;
  assign w_drop   = w_sop & r_ready[r_wbank];
  assign w_accept = w_sop & ~r_ready[r_wbank];
  assign w_byte   = ts_din_en & ~ts_din_sync & r_open;

`ifdef NULL_PID_DROP_EN
  logic [4:0] r_pid_hi;
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst)                        r_pid_hi <= '0;
    else if (w_byte && r_bcnt == 8'd1) r_pid_hi <= ts_din[4:0];
  end
  assign w_null = w_byte && (r_bcnt == 8'd2) && ({r_pid_hi, ts_din} == 13'h1FFF);
`else
  assign w_null = 1'b0;
`endif

  assign w_commit = w_byte & (r_bcnt == 8'd187);
  assign w_tmo    = r_tmr_run & (r_tcnt == TW'(TIMEOUT_CYC));
  assign w_full   = w_commit & (r_npkt == 3'(PKTS_PER_FRAME - 1));
  // A timeout waits for any open packet to finish so no committed-but-partial data is lost.
  assign w_close  = w_full | (w_tmo & w_commit) | (w_tmo & ~r_open & ~w_sop);
  assign w_close_len = 11'(({8'd0, r_npkt} + {10'd0, w_commit}) * 11'd188);

  assign w_we    = w_accept | w_byte;
  assign w_off   = w_accept ? 8'd0 : r_bcnt;
  assign w_waddr = {r_wbank, r_base + {3'b000, w_off}};

  always_ff @(posedge tx_clk) begin
    if (w_we) r_mem[w_waddr] <= ts_din;
    r_rdata <= r_mem[{r_rbank, r_raddr}];
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_wbank   <= 1'b0;
      r_open    <= 1'b0;
      r_bcnt    <= '0;
      r_base    <= '0;
      r_npkt    <= '0;
      r_ready   <= '0;
      r_flen    <= '0;
      r_tmr_run <= 1'b0;
      r_tcnt    <= '0;
      r_drop    <= '0;
    end else begin
      if (w_accept) begin
        r_open <= 1'b1;
        r_bcnt <= 8'd1;
      end else if (w_byte) begin
        if (w_commit || w_null) begin
          r_open <= 1'b0;
          r_bcnt <= '0;
        end else begin
          r_bcnt <= r_bcnt + 8'd1;
        end
      end
      if (r_tmr_run && !w_tmo) r_tcnt <= r_tcnt + TW'(1);
      if (w_close) begin
        r_wbank          <= ~r_wbank;
        r_base           <= '0;
        r_npkt           <= '0;
        r_tmr_run        <= 1'b0;
        r_ready[r_wbank] <= 1'b1;
        r_flen[r_wbank]  <= w_close_len;
      end else if (w_commit) begin
        r_base <= r_base + 11'd188;
        r_npkt <= r_npkt + 3'd1;
        if (!r_tmr_run) begin
          r_tmr_run <= 1'b1;
          r_tcnt    <= '0;
        end
      end
      // The reader only ever frees the bank the writer is not filling.
      if (w_free) r_ready[r_rbank] <= 1'b0;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  always_comb begin
    w_st_nxt = r_st;
    w_free   = 1'b0;
    w_latch  = 1'b0;
    case (r_st)
      S_IDLE:  if (r_ready[r_rbank]) w_st_nxt = S_CHECK;
      S_CHECK: if (!udp_prog_full) begin
        w_latch  = 1'b1;
        w_st_nxt = S_READ;
      end
      S_READ:  if (r_raddr == r_len - 11'd1) begin
        w_free   = 1'b1;
        w_st_nxt = S_GAP;
      end
      S_GAP:   w_st_nxt = S_IDLE;
      default: w_st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_st       <= S_IDLE;
      r_rbank    <= 1'b0;
      r_raddr    <= '0;
      r_len      <= '0;
      r_vld_pipe <= '0;
      r_dout     <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (w_latch) begin
        r_len   <= r_flen[r_rbank];
        r_raddr <= '0;
      end else if (r_st == S_READ) begin
        r_raddr <= r_raddr + 11'd1;
      end
      if (r_st == S_GAP) r_rbank <= ~r_rbank;
      r_vld_pipe <= {r_vld_pipe[0], r_st == S_READ};
      if (r_vld_pipe[0]) r_dout <= r_rdata;
    end
  end

  assign udp_din       = r_dout;
  assign udp_din_en    = r_vld_pipe[1];
  assign udp_frame_len = r_len;
  assign drop_cnt      = r_drop;

endmodule

// File: tb/tb_ts_udp_packer.sv
// Bench for ts_udp_packer: table-driven frame scenarios, hand-written corner sequences, random groups.
module tb_ts_udp_packer;
  logic        tx_clk = 1'b0, tx_rst = 1'b1;
  logic [7:0]  ts_din = '0;
  logic        ts_din_en = 1'b0, ts_din_sync = 1'b0, udp_prog_full = 1'b0;
  logic [7:0]  udp_din;
  logic        udp_din_en;
  logic [10:0] udp_frame_len;
  logic [15:0] drop_cnt;

  ts_udp_packer #(.PKTS_PER_FRAME(7), .TIMEOUT_CYC(1000)) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .ts_din(ts_din), .ts_din_en(ts_din_en),
    .ts_din_sync(ts_din_sync), .udp_prog_full(udp_prog_full), .udp_din(udp_din),
    .udp_din_en(udp_din_en), .udp_frame_len(udp_frame_len), .drop_cnt(drop_cnt));

  always #4 tx_clk = ~tx_clk;

  typedef struct { int abort_at; int npkts; int nfr; int len0; int len1; int drops; } vec_t;
  vec_t vecs[6];

  int n_tests = 0, n_fail = 0, cyc = 0, t_last = 0;
  logic [7:0] pbuf [188];
  logic [7:0] exp_data[$], rx_data[$];
  int exp_lens[$], rx_len[$], rx_flen[$], rx_chg[$], rx_start[$];
  bit in_fr = 0;
  int cur_len, cur_flen, cur_chg;

  always @(posedge tx_clk) cyc++;

  always @(negedge tx_clk) begin
    if (tx_rst) in_fr = 0;
    else if (udp_din_en) begin
      if (!in_fr) begin
        in_fr = 1; cur_len = 0; cur_flen = int'(udp_frame_len); cur_chg = 0;
        rx_start.push_back(cyc);
      end
      cur_len++;
      if (int'(udp_frame_len) != cur_flen) cur_chg = 1;
      rx_data.push_back(udp_din);
    end else if (in_fr) begin
      in_fr = 0;
      rx_len.push_back(cur_len); rx_flen.push_back(cur_flen); rx_chg.push_back(cur_chg);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b, input bit s);
    @(posedge tx_clk); #1;
    ts_din = b; ts_din_en = 1'b1; ts_din_sync = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge tx_clk); #1;
      ts_din_en = 1'b0; ts_din_sync = 1'b0;
    end
  endtask

  task automatic fill_pat(input int p);
    for (int k = 0; k < 188; k++) pbuf[k] = 8'((p * 16 + k) % 256);
  endtask

  task automatic fill_junk();
    for (int k = 0; k < 188; k++) pbuf[k] = 8'hEE;
    pbuf[0] = 8'h47;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 188; k++) pbuf[k] = 8'($urandom);
    pbuf[1] = pbuf[1] & 8'h0F;
  endtask

  task automatic send_buf(input int nb, input bit push);
    for (int k = 0; k < nb; k++) drive(pbuf[k], k == 0);
    t_last = cyc + 1;
    if (push) for (int k = 0; k < nb; k++) exp_data.push_back(pbuf[k]);
  endtask

  task automatic clear_q();
    exp_data.delete(); exp_lens.delete(); rx_data.delete();
    rx_len.delete(); rx_flen.delete(); rx_chg.delete(); rx_start.delete();
  endtask

  task automatic do_reset();
    @(posedge tx_clk); #1;
    tx_rst = 1'b1; ts_din_en = 1'b0; ts_din_sync = 1'b0; udp_prog_full = 1'b0;
    repeat (3) @(posedge tx_clk);
    #1 tx_rst = 1'b0;
    clear_q();
  endtask

  task automatic wait_frames(input string nm, input int n, input int budget);
    int c = 0;
    while (rx_len.size() < n && c < budget) begin idle(1); c++; end
    chk({nm, " frame wait"}, int'(rx_len.size() >= n), 1);
    idle(4);
  endtask

  task automatic compare_all(input string nm);
    int n, mism;
    chk({nm, " nframes"}, rx_len.size(), exp_lens.size());
    n = (rx_len.size() < exp_lens.size()) ? rx_len.size() : exp_lens.size();
    for (int i = 0; i < n; i++) begin
      chk({nm, " run len"}, rx_len[i], exp_lens[i]);
      chk({nm, " frame_len"}, rx_flen[i], exp_lens[i]);
      chk({nm, " frame_len stable"}, rx_chg[i], 0);
    end
    chk({nm, " byte count"}, rx_data.size(), exp_data.size());
    mism = 0;
    n = (rx_data.size() < exp_data.size()) ? rx_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) if (rx_data[i] != exp_data[i]) mism++;
    chk({nm, " byte mismatches"}, mism, 0);
    clear_q();
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t0, n, gap;
    vecs[0] = '{abort_at: 0,   npkts: 7,  nfr: 1, len0: 1316, len1: 0,    drops: 0};
    vecs[1] = '{abort_at: 0,   npkts: 3,  nfr: 1, len0: 564,  len1: 0,    drops: 0};
    vecs[2] = '{abort_at: 0,   npkts: 1,  nfr: 1, len0: 188,  len1: 0,    drops: 0};
    vecs[3] = '{abort_at: 100, npkts: 1,  nfr: 1, len0: 188,  len1: 0,    drops: 0};
    vecs[4] = '{abort_at: 187, npkts: 7,  nfr: 1, len0: 1316, len1: 0,    drops: 0};
    vecs[5] = '{abort_at: 0,   npkts: 8,  nfr: 2, len0: 1316, len1: 188,  drops: 0};

    do_reset();
    chk("reset udp_din", int'(udp_din), 0);
    chk("reset udp_din_en", int'(udp_din_en), 0);
    chk("reset udp_frame_len", int'(udp_frame_len), 0);
    chk("reset drop_cnt", int'(drop_cnt), 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      if (vecs[v].abort_at > 0) begin fill_junk(); send_buf(vecs[v].abort_at, 0); end
      for (int p = 0; p < vecs[v].npkts; p++) begin fill_pat(p); send_buf(188, 1); end
      exp_lens.push_back(vecs[v].len0);
      if (vecs[v].nfr == 2) exp_lens.push_back(vecs[v].len1);
      wait_frames($sformatf("vec%0d", v), vecs[v].nfr, 4000);
      chk($sformatf("vec%0d drop_cnt", v), int'(drop_cnt), vecs[v].drops);
      compare_all($sformatf("vec%0d", v));
    end

    // Partial frame flushed by the timeout, measured from the first commit.
    do_reset();
    fill_pat(0); send_buf(188, 1); t0 = t_last;
    fill_pat(1); send_buf(188, 1);
    fill_pat(2); send_buf(188, 1);
    exp_lens.push_back(564);
    wait_frames("tmo", 1, 3000);
    k = (rx_start.size() > 0) ? rx_start[0] - t0 : -1;
    chk("tmo start window", int'(k >= 1000 && k <= 1010), 1);
    compare_all("tmo");

    // prog_full held, then released; asserted again mid-burst.
    do_reset();
    udp_prog_full = 1'b1;
    for (int p = 0; p < 7; p++) begin fill_pat(p); send_buf(188, 1); end
    idle(5000);
    chk("pf hold no output", rx_start.size(), 0);
    @(posedge tx_clk); #1 udp_prog_full = 1'b0;
    k = 0;
    do begin @(negedge tx_clk); k++; end while (!udp_din_en && k < 20);
    chk("check to en latency", k, 4);
    repeat (100) @(posedge tx_clk);
    #1 udp_prog_full = 1'b1;
    exp_lens.push_back(1316);
    wait_frames("pf mid", 1, 2000);
    udp_prog_full = 1'b0;
    compare_all("pf mid");

    // Both banks full: the last two packets are dropped.
    do_reset();
    udp_prog_full = 1'b1;
    for (int p = 0; p < 16; p++) begin fill_pat(p); send_buf(188, p < 14); end
    idle(10);
    chk("ovf drop_cnt", int'(drop_cnt), 2);
    chk("ovf no output", rx_start.size(), 0);
    @(posedge tx_clk); #1 udp_prog_full = 1'b0;
    exp_lens.push_back(1316); exp_lens.push_back(1316);
    wait_frames("ovf", 2, 4000);
    k = (rx_start.size() > 1) ? rx_start[1] - (rx_start[0] + rx_len[0]) : 0;
    chk("ovf inter-frame gap", int'(k >= 1), 1);
    compare_all("ovf");

    // Null-PID packet in position 3.
    do_reset();
    for (int p = 0; p < 7; p++) begin
      fill_pat(p);
      if (p == 3) begin pbuf[1] = 8'h1F; pbuf[2] = 8'hFF; end
`ifdef NULL_PID_DROP_EN
      send_buf(188, p != 3);
`else
      send_buf(188, 1);
`endif
    end
`ifdef NULL_PID_DROP_EN
    exp_lens.push_back(1128);
`else
    exp_lens.push_back(1316);
`endif
    wait_frames("nullpid", 1, 4000);
    chk("nullpid drop_cnt", int'(drop_cnt), 0);
    compare_all("nullpid");

    // Reset in the middle of a burst.
    do_reset();
    for (int p = 0; p < 7; p++) begin fill_pat(p); send_buf(188, 0); end
    k = 0;
    while (!udp_din_en && k < 3000) begin idle(1); k++; end
    chk("rstmid saw burst", int'(udp_din_en), 1);
    repeat (50) @(posedge tx_clk);
    #1 tx_rst = 1'b1;
    @(negedge tx_clk);
    chk("rstmid udp_din_en", int'(udp_din_en), 0);
    chk("rstmid udp_frame_len", int'(udp_frame_len), 0);
    chk("rstmid udp_din", int'(udp_din), 0);
    repeat (2) @(posedge tx_clk);
    #1 tx_rst = 1'b0;
    clear_q();
    idle(3000);
    chk("rstmid no resume", rx_start.size(), 0);

    // Random groups: optional aborted prefix, 1..7 packets with short gaps.
    do_reset();
    for (int g = 0; g < 8; g++) begin
      if ($urandom_range(0, 2) == 0) begin fill_junk(); send_buf($urandom_range(1, 187), 0); end
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        fill_rand(); send_buf(188, 1);
        gap = $urandom_range(0, 3);
        if (i < n - 1) idle(gap);
      end
      exp_lens.push_back(n * 188);
      wait_frames($sformatf("rand%0d", g), 1, 4000);
      compare_all($sformatf("rand%0d", g));
    end
    chk("rand drop_cnt", int'(drop_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
